// File: rtl/dram_responder.sv
`default_nettype none
// ============================================================================
// Module      : dram_responder
// Description : Memory-side responder for the core's external-DRAM request
//               interface. It accepts one request at a time and serves it
//               from an internal array of 32-bit words. Each request finishes
//               with a single-cycle ready_dram pulse, LATENCY cycles after
//               the request is accepted.
//
// Parameters  : ADDR_W  - word-index width; the array has 2**ADDR_W words
//               LATENCY - cycles from accept to ready_dram (1..255)
//
// Ports       : clk         in   clock, rising edge
//               rst         in   synchronous active-high reset
//               valid_dram  in   request present
//               rw_dram     in   1 = write, 0 = read (sampled at accept)
//               addr_dram   in   halfword address; word = addr_dram[ADDR_W:1]
//               din_dram    in   write data (sampled at accept)
//               ready_dram  out  one-cycle completion pulse
//               dout_dram   out  read data; holds between read responses
//               busy        out  a request is outstanding
//               addr_err    out  sticky out-of-range flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module dram_responder #(
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_dram,
  input  logic        rw_dram,
  input  logic [26:0] addr_dram,
  input  logic [31:0] din_dram,
  output logic        ready_dram,
  output logic [31:0] dout_dram,
  output logic        busy,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t            state;
  state_t            state_next;
  logic [7:0]        cnt;

  // Request latched at accept. Write data is not kept: writes are committed
  // into the array on the accept edge itself.
  logic              req_rw;
  logic [ADDR_W-1:0] req_idx;
  logic              req_oor;

  logic [ADDR_W-1:0] in_idx;
  logic              in_oor;
  logic              accept;
  logic              rd_now;
  logic [ADDR_W-1:0] rd_idx;
  logic              rd_oor;

  logic [31:0]       mem [2**ADDR_W];

  // Bit 0 of the halfword address never selects anything.
  logic              unused_addr_lsb;
  assign unused_addr_lsb = addr_dram[0];

  assign in_idx = addr_dram[ADDR_W:1];

  // Any address bit above the word index makes the request out of range.
  // With a full-width index there are no such bits.
  if (ADDR_W < 26) begin : g_range_check
    assign in_oor = |addr_dram[26:ADDR_W+1];
  end else begin : g_no_range_check
    assign in_oor = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rd_now     = 1'b0;
    rd_idx     = req_idx;
    rd_oor     = req_oor;
    case (state)
      IDLE: begin
        if (valid_dram) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            // No WAIT phase: the array is read on the accept edge itself,
            // straight from the incoming address.
            state_next = RESP;
            rd_now     = !rw_dram;
            rd_idx     = in_idx;
            rd_oor     = in_oor;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        // The read is timed so that dout is loaded on the edge entering RESP.
        if (cnt == 8'd1) begin
          state_next = RESP;
          rd_now     = !req_rw;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, request latch, counter, read data and error flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      req_rw    <= 1'b0;
      req_idx   <= '0;
      req_oor   <= 1'b0;
      dout_dram <= 32'h0;
      addr_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        req_rw  <= rw_dram;
        req_idx <= in_idx;
        req_oor <= in_oor;
        cnt     <= CNT_INIT;
        if (in_oor) begin
          addr_err <= 1'b1;
        end
      end else if (state == WAIT) begin
        cnt <= cnt - 8'd1;
      end
      if (rd_now) begin
        dout_dram <= rd_oor ? 32'h0 : mem[rd_idx];
      end
    end
  end

  // Array write on the accept edge. The array has no reset, so a write that
  // is later interrupted by rst still stays committed.
  always_ff @(posedge clk) begin
    if (!rst && accept && rw_dram && !in_oor) begin
      mem[in_idx] <= din_dram;
    end
  end

  assign ready_dram = (state == RESP);
  assign busy       = (state != IDLE);

endmodule
`default_nettype wire
